// File: rtl/sideband_deserializer_if.sv
// Sideband receive interface: serial line in, recovered parallel word and status strobes out.
// The master drives the line; the slave (the deserializer) drives the outputs.
interface sideband_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             sb_in;
    logic [WIDTH-1:0] parallel_out;
    logic             data_valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output sb_in,
        input  parallel_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  sb_in,
        output parallel_out,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/sideband_deserializer.sv
// Recovers start/data/stop framed words from the one-bit-per-clock sideband line and
// presents each good word with a one-cycle valid strobe; bad stop bits raise frame_err.
module sideband_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sideband_deserializer_if.slave sb
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DATA      = 2'd1;
    localparam logic [1:0] STOP      = 2'd2;
    localparam logic [1:0] WAIT_HIGH = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             err_q;

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would let later statements see updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sb.sb_in) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    shreg <= {sb.sb_in, shreg[WIDTH-1:1]};
                    // Hold the counter on the last bit so it never wraps past WIDTH-1.
                    if (cnt == LAST_BIT) begin
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (sb.sb_in) begin
                        word_q  <= shreg;
                        valid_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        err_q <= 1'b1;
                        state <= WAIT_HIGH;
                    end
                end
                default: begin
                    // A low line after a framing error is a break, not a start bit.
                    if (sb.sb_in) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign sb.parallel_out = word_q;
    assign sb.data_valid   = valid_q;
    assign sb.frame_err    = err_q;
    assign sb.busy         = (state != IDLE);
endmodule

// File: tb/tb_sideband_deserializer.sv
// Directed bench for sideband_deserializer: expected pulses are queued when frames are
// driven and matched (kind, cycle, word) when the DUT strobes.
module tb_sideband_deserializer;
    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t mon_e;
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sideband_deserializer_if #(.WIDTH(8)) sb8 ();
    sideband_deserializer_if #(.WIDTH(4)) sb4 ();

    sideband_deserializer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .sb(sb8.slave));
    sideband_deserializer #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .sb(sb4.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Pulse monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (sb8.data_valid === 1'b1 || sb8.frame_err === 1'b1) begin
                check("pulse_exclusive", 32'(sb8.data_valid & sb8.frame_err), 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_pulse_queue", 32'(q.size()), 32'd1);
                end else begin
                    mon_e = q.pop_front();
                    check("pulse_kind_err", 32'(sb8.frame_err), 32'(mon_e.is_err));
                    check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("pulse_word", 32'(sb8.parallel_out), 32'(mon_e.data));
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                check("pulse_missing_cycle", 32'(cyc), 32'(q[0].cyc));
                void'(q.pop_front());
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop, input int idle_after);
        exp_t e;
        @(negedge clk);
        sb8.sb_in = 1'b0;
        e.cyc    = cyc + 10;
        e.is_err = !stop;
        e.data   = stop ? d : last_good;
        if (stop) last_good = d;
        q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check("busy_in_frame", 32'(sb8.busy), 32'd1);
            sb8.sb_in = d[i];
        end
        @(negedge clk);
        sb8.sb_in = stop;
        repeat (idle_after) begin
            @(negedge clk);
            sb8.sb_in = 1'b1;
        end
    endtask

    task automatic drain();
        int budget = 40;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) check("drain_timeout_pending", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] d4;
        rst       = 1'b1;
        sb8.sb_in = 1'b1;
        sb4.sb_in = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_word", 32'(sb8.parallel_out), 32'd0);
        check("reset_busy", 32'(sb8.busy), 32'd0);
        rst = 1'b0;

        // Idle line: nothing moves.
        repeat (20) begin
            @(negedge clk);
            check("idle_busy", 32'(sb8.busy), 32'd0);
            check("idle_valid", 32'(sb8.data_valid), 32'd0);
            check("idle_err", 32'(sb8.frame_err), 32'd0);
            check("idle_word", 32'(sb8.parallel_out), 32'd0);
        end

        send_frame(8'hA5, 1'b1, 4);
        drain();
        repeat (3) @(negedge clk);
        check("hold_a5", 32'(sb8.parallel_out), 32'hA5);
        check("idle_after_a5", 32'(sb8.busy), 32'd0);

        // Back-to-back, no idle bit between frames.
        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 3);
        drain();

        // Good frame, bad stop, long break, then recovery.
        send_frame(8'h5A, 1'b1, 0);
        send_frame(8'h81, 1'b0, 0);
        repeat (15) @(negedge clk);
        check("break_busy", 32'(sb8.busy), 32'd1);
        check("break_word", 32'(sb8.parallel_out), 32'h5A);
        @(negedge clk);
        sb8.sb_in = 1'b1;
        send_frame(8'h0F, 1'b1, 2);
        drain();
        check("after_0f", 32'(sb8.parallel_out), 32'h0F);

        // Asynchronous reset in the middle of an 8'hC3 frame.
        @(negedge clk);
        sb8.sb_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sb8.sb_in = (i < 2) ? 1'b1 : 1'b0;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_word", 32'(sb8.parallel_out), 32'd0);
        check("async_rst_busy", 32'(sb8.busy), 32'd0);
        check("async_rst_valid", 32'(sb8.data_valid), 32'd0);
        check("async_rst_err", 32'(sb8.frame_err), 32'd0);
        last_good = 8'h00;
        repeat (2) @(negedge clk);
        sb8.sb_in = 1'b1;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 32'(sb8.busy), 32'd0);
        send_frame(8'h96, 1'b1, 2);
        drain();
        check("after_96", 32'(sb8.parallel_out), 32'h96);

        // WIDTH=4 instance: d0..d3 = 1,1,0,1.
        d4 = 4'hB;
        @(negedge clk);
        sb4.sb_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("w4_no_early_valid", 32'(sb4.data_valid), 32'd0);
            sb4.sb_in = d4[i];
        end
        @(negedge clk);
        check("w4_no_early_valid", 32'(sb4.data_valid), 32'd0);
        sb4.sb_in = 1'b1;
        @(negedge clk);
        check("w4_valid", 32'(sb4.data_valid), 32'd1);
        check("w4_word", 32'(sb4.parallel_out), 32'hB);
        check("w4_err", 32'(sb4.frame_err), 32'd0);
        @(negedge clk);
        check("w4_valid_one_cycle", 32'(sb4.data_valid), 32'd0);
        check("w4_busy_done", 32'(sb4.busy), 32'd0);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sideband_deserializer.md
Name: sideband_deserializer

Overview:
- Receive-side counterpart of the sideband bit-serial transmit path.
- Recovers UART-style framed bytes from the single-bit sideband line. Each frame is: start bit 0, WIDTH data bits LSB first, stop bit 1.
- Presents each recovered byte as a parallel word with a one-cycle valid strobe to the sideband transaction/packet parser.
- Runs at one bit per clock, the same bit rate as the sideband serializer.

Parameters:
WIDTH, 8, number of data bits per frame (parallel output width); WIDTH >= 2
CNT_W, $clog2(WIDTH), width of the data-bit counter (derived localparam, not overridable)

Ports:
clk  input  1  sideband clock; every transition occurs on the rising edge
rst  input  1  asynchronous, active-high reset
sb_in  input  1  serial sideband line; idles high; sampled once per rising edge of clk
parallel_out  output  WIDTH  last correctly framed data word; bit 0 is the first data bit received
data_valid  output  1  one-cycle pulse: parallel_out has just been updated with a new word
frame_err  output  1  one-cycle pulse: stop bit sampled as 0; word discarded
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous assert, active-high): state=IDLE, parallel_out=0, data_valid=0, frame_err=0, busy=0, shift register=0, counter=0. Reset has priority over everything.
- Reset mid-frame: the partial frame is dropped. No valid or error pulse is issued. After release, the block hunts for a fresh start bit from IDLE.
- FSM states: IDLE, DATA, STOP, WAIT_HIGH.
- IDLE:
  - sb_in sampled 0 -> DATA, counter=0. This is the start bit, edge t0.
  - sb_in sampled 1 -> stay in IDLE.
- DATA:
  - On each edge, shift sb_in in at the MSB end: shreg <= {sb_in, shreg[WIDTH-1:1]}.
  - The counter increments on each DATA edge.
  - On the edge where counter==WIDTH-1 (edge tWIDTH), go to STOP.
  - Edges t1..tWIDTH carry d0..d(WIDTH-1). After tWIDTH, shreg[i]=di.
- STOP (edge tWIDTH+1):
  - sb_in=1 -> parallel_out<=shreg, data_valid<=1, go to IDLE.
  - sb_in=0 -> frame_err<=1, parallel_out unchanged, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay while sb_in=0. This suppresses false starts during a break or stuck-low line.
  - sb_in sampled 1 -> IDLE. That sample is never interpreted as a start bit.
- Latency: data_valid is high for exactly the cycle following the stop-bit edge, i.e. WIDTH+2 clocks after the start-bit edge.
- Pulse widths: data_valid and frame_err are registered and high for exactly one cycle. They are never high in the same cycle.
- parallel_out holds its value until the next good frame; it is not cleared on error.
- Back-to-back frames:
  - A start bit sampled on the edge immediately after the stop bit is accepted, because IDLE is entered after STOP.
  - Minimum frame period is WIDTH+2 clocks, with no idle bits required between frames.
- busy:
  - Combinational from state: (state != IDLE).
  - High from the cycle after the start-bit edge until the return to IDLE.
- Data bits are not glitch-filtered or majority-voted: the single sample per clock is authoritative.
- Counter: CNT_W bits, no wrap beyond WIDTH-1. It is reset to 0 on every entry to DATA.

Test Plan:
1. Reset, then sb_in=1 for 20 cycles -> busy=0, data_valid=0, frame_err=0, parallel_out=8'h00 throughout.
2. Frame 0,{1,0,1,0,0,1,0,1},1 (byte 8'hA5, LSB first) -> data_valid pulses one cycle, exactly 10 clocks after the start edge. parallel_out=8'hA5 and holds afterwards.
3. Back-to-back frames 8'h3C then 8'hFF with no idle gap -> two data_valid pulses 10 cycles apart. parallel_out reads 8'h3C, then 8'hFF. frame_err stays 0.
4. Good frame 8'h5A, then a frame 8'h81 with stop bit 0, then line low for 15 cycles, then high, then frame 8'h0F:
   - the bad frame gives one frame_err pulse and parallel_out stays 8'h5A;
   - there are no further pulses while the line is low;
   - the 8'h0F frame is received correctly.
5. Assert rst asynchronously (between edges) after the 4th data bit of an 8'hC3 frame; hold 2 cycles; release with sb_in=1 -> outputs return to reset values immediately, with no pulses. A following 8'h96 frame yields parallel_out=8'h96.
6. WIDTH=4 instance, frame 0,{1,1,0,1},1 -> data_valid 6 clocks after the start edge, parallel_out=4'hB.
